systemizer_mem: RTL

SYSTEMIZER_MEM -- requirements
Module: systemizer_mem

---
 rtl/systemizer_mem_pkg.sv | 25 ++
 rtl/systemizer_mem_sys_ram.sv | 30 +++
 rtl/systemizer_mem.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/systemizer_mem_pkg.sv
// Shared sizing defaults, CLOG2 helper and FSM encoding for the systemizer matrix memory.
package systemizer_mem_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) result = i + 32'sd1;
      end
      return result;
   endfunction

   localparam int DEPTH_DEF = 40;
   localparam int DW_DEF    = 2 * clog2(3);
   localparam int AW_DEF    = clog2(DEPTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_DUMP  = 3'd4
   } state_t;

endpackage

// File: rtl/systemizer_mem_sys_ram.sv
// Single-clock matrix word store: one write port, one registered read-first read port.
module sys_ram
   import systemizer_mem_pkg::*;
#(
   parameter int  DEPTH = DEPTH_DEF,
   parameter int  DW    = DW_DEF,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_r [DEPTH];

   // Write port; the caller only presents in-range addresses.
   always_ff @(posedge clk) begin
      if (we) mem_r[waddr] <= wdata;
   end

   // Registered read; sampling before the write lands gives old data on a collision.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem_r[raddr];
   end

endmodule

// File: rtl/systemizer_mem.sv
// Matrix memory front end: host load/dump sequencing around a systemizer run window.
module systemizer_mem
   import systemizer_mem_pkg::*;
#(
   parameter int  DEPTH = DEPTH_DEF,
   parameter int  DW    = DW_DEF,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          host_load,
   input  logic          host_go,
   input  logic          host_in_valid,
   input  logic [DW-1:0] host_in_data,
   output logic          host_out_valid,
   output logic [DW-1:0] host_out_data,
   input  logic          host_out_ready,
   output logic          load_done,
   output logic          err,
   output logic          sys_start,
   input  logic          sys_done,
   input  logic          sys_rd_en,
   input  logic [AW-1:0] sys_rd_addr,
   output logic [DW-1:0] sys_rd_data,
   input  logic          sys_wr_en,
   input  logic [AW-1:0] sys_wr_addr,
   input  logic [DW-1:0] sys_wr_data
);

   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

   state_t        state_r, state_s;
   logic [AW-1:0] cnt_r;
   logic          sys_start_r, load_done_r, err_r;
   logic          dump_pend_r, host_out_valid_r;
   logic [DW-1:0] host_out_data_r;
   logic          sys_rd_fresh_r;
   logic [DW-1:0] sys_rd_hold_r;

   logic          in_run_s, rd_ok_s, wr_ok_s, bad_s;
   logic          load_wr_s, load_last_s, accept_s, dump_last_s, issue_s;
   logic          ram_we_s, ram_re_s;
   logic [AW-1:0] ram_waddr_s, ram_raddr_s;
   logic [DW-1:0] ram_wdata_s, ram_q_s;

   assign in_run_s    = (state_r == ST_RUN);
   assign rd_ok_s     = in_run_s && sys_rd_en && ({1'b0, sys_rd_addr} < DEPTH_X);
   assign wr_ok_s     = in_run_s && sys_wr_en && ({1'b0, sys_wr_addr} < DEPTH_X);
   assign bad_s       = in_run_s && ((sys_rd_en && !rd_ok_s) || (sys_wr_en && !wr_ok_s));
   assign load_wr_s   = (state_r == ST_LOAD) && host_in_valid && !host_load;
   assign load_last_s = load_wr_s && (cnt_r == LAST);
   assign accept_s    = (state_r == ST_DUMP) && host_out_valid_r && host_out_ready;
   assign dump_last_s = accept_s && (cnt_r == LAST);
   // Fetch the first word on entry, then prefetch the next word on each acceptance.
   assign issue_s     = (state_r == ST_DUMP) &&
                        ((!host_out_valid_r && !dump_pend_r) || (accept_s && (cnt_r != LAST)));

   // Route the RAM ports to whichever agent owns the array in the current state.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = cnt_r;
      ram_wdata_s = host_in_data;
      ram_re_s    = 1'b0;
      ram_raddr_s = cnt_r;
      case (state_r)
         ST_LOAD: ram_we_s = load_wr_s;
         ST_RUN: begin
            ram_we_s    = wr_ok_s;
            ram_waddr_s = sys_wr_addr;
            ram_wdata_s = sys_wr_data;
            ram_re_s    = rd_ok_s;
            ram_raddr_s = sys_rd_addr;
         end
         ST_DUMP: begin
            ram_re_s    = issue_s;
            ram_raddr_s = accept_s ? (cnt_r + AW'(1)) : cnt_r;
         end
         default: ram_we_s = 1'b0;
      endcase
   end

   sys_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (ram_waddr_s),
      .wdata (ram_wdata_s),
      .re    (ram_re_s),
      .raddr (ram_raddr_s),
      .rdata (ram_q_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = host_load   ? ST_LOAD  : ST_IDLE;
         ST_LOAD:  state_s = load_last_s ? ST_READY : ST_LOAD;
         ST_READY: state_s = host_go     ? ST_RUN   : ST_READY;
         ST_RUN:   state_s = sys_done    ? ST_DUMP  : ST_RUN;
         ST_DUMP:  state_s = dump_last_s ? ST_IDLE  : ST_DUMP;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Shared load/dump word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: if (host_load) cnt_r <= {AW{1'b0}};
            ST_LOAD: begin
               if (host_load || load_last_s) cnt_r <= {AW{1'b0}};
               else if (load_wr_s)           cnt_r <= cnt_r + AW'(1);
            end
            ST_RUN:  if (sys_done) cnt_r <= {AW{1'b0}};
            ST_DUMP: begin
               if (dump_last_s)   cnt_r <= {AW{1'b0}};
               else if (accept_s) cnt_r <= cnt_r + AW'(1);
            end
            default: cnt_r <= {AW{1'b0}};
         endcase
      end
   end

   // Status flags: one-shot start, load completion, sticky address error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_start_r <= 1'b0;
         load_done_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         sys_start_r <= (state_r == ST_READY) && host_go;
         err_r       <= err_r | bad_s;
         if (load_last_s)            load_done_r <= 1'b1;
         else if (in_run_s && sys_done) load_done_r <= 1'b0;
      end
   end

   // Dump output register: loads one cycle after each fetch, holds through stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dump_pend_r      <= 1'b0;
         host_out_valid_r <= 1'b0;
         host_out_data_r  <= {DW{1'b0}};
      end else begin
         dump_pend_r <= issue_s;
         if (dump_pend_r) begin
            host_out_valid_r <= 1'b1;
            host_out_data_r  <= ram_q_s;
         end else if (accept_s) begin
            host_out_valid_r <= 1'b0;
         end
      end
   end

   // The RAM read register is shared with dump, so keep a held copy of the last systemizer result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_rd_fresh_r <= 1'b0;
         sys_rd_hold_r  <= {DW{1'b0}};
      end else begin
         sys_rd_fresh_r <= rd_ok_s;
         sys_rd_hold_r  <= (in_run_s && sys_rd_en && !rd_ok_s) ? {DW{1'b0}} : sys_rd_data;
      end
   end

   assign sys_rd_data    = sys_rd_fresh_r ? ram_q_s : sys_rd_hold_r;
   assign sys_start      = sys_start_r;
   assign load_done      = load_done_r;
   assign err            = err_r;
   assign host_out_valid = host_out_valid_r;
   assign host_out_data  = host_out_data_r;

endmodule
